microp_mem_responder: RTL and testbench
=======================================

# microp_mem_responder

Single-port 32-bit word memory responder that serves the pipelined core's two memory initiators: instruction fetch (IF) and load/store data (DM). Each channel uses a valid/ready request handshake and a one-deep buffered response with its own valid/ready. The block arbitrates both channels onto one shared 2^AW-word array, so the core can stall on memory instead of owning the array.

## Interface
- AW, 10: word-address width; depth is 2^AW words.
- DW, 32: data width.
- clk1  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- if_req_valid  in  1  IF read request.
- if_req_ready  out  1  IF request accepted this edge when high with valid.
- if_req_addr  in  32  IF word address.
- if_rsp_valid  out  1  IF response held in slot.
- if_rsp_ready  in  1  core consumes IF response.
- if_rsp_data  out  DW  IF read data.
- if_rsp_err  out  1  IF address out of range.
- dm_req_valid  in  1  DM request.
- dm_req_ready  out  1  DM request accepted.
- dm_req_we  in  1  1 = store, 0 = load.
- dm_req_addr  in  32  DM word address.
- dm_req_wdata  in  DW  store data.
- dm_rsp_valid  out  1  DM response (load data or store ack).
- dm_rsp_ready  in  1  core consumes DM response.
- dm_rsp_data  out  DW  load data; 0 for stores.
- dm_rsp_err  out  1  DM address out of range.

## Operation
- Slot free for channel X: !X_rsp_valid || X_rsp_ready.
- Eligible: X_req_valid && slot free.
- Arbitration:
  - One eligible channel: grant it.
  - Both eligible: grant the channel named by the `prio` flop, then toggle `prio`.
  - `prio` is unchanged in uncontested cycles.
- X_req_ready = slot free && !(other channel eligible && prio == other). It is combinational from valids/rsp_ready/prio; no combinational path from X_req_valid to X_req_ready.
- At most one array access per cycle.
- Range check: addr[31:AW] != 0 gives err=1 and data=0; a store to such an address is dropped and the array is not modified.
- Load / IF read: data = array[addr[AW-1:0]] registered into the slot on the accept edge.
- Store: on the accept edge, array[addr] <= wdata. The response carries data=0 and err as computed.
- Response slot states:
  - EMPTY: transitions to FULL on grant.
  - FULL: transitions to EMPTY on rsp_ready with no grant.
  - FULL with rsp_ready and a grant in the same edge: stays FULL, loaded with the new response.
- Output data and err are stable while rsp_valid && !rsp_ready.
- Array contents are not reset.

## Timing
- Reset values: if_rsp_valid=0, dm_rsp_valid=0, *_rsp_data=0, *_rsp_err=0, prio=DM.
- Latency: request accepted at edge N gives rsp_valid=1 from N+1. Throughput is one response per cycle per channel with rsp_ready held high; the shared array gives one per cycle total.
- Store accepted at edge N followed by a read of the same address accepted at edge N+1 or later returns the new data.
- Contended cycle sequence with prio=DM: DM, IF, DM, ... while both remain eligible.
- rst asserted mid-operation: both slots return to EMPTY and prio=DM on that edge. Requests presented in a reset cycle are not accepted (ready forced 0 while rst). A store presented with rst does not write.

## Structure
- Package microp_mem_pkg: AW and DW defaults, port-id enum {PORT_DM=0, PORT_IF=1} used for `prio`, and a range-check function.
- Sub-module microp_rsp_slot (one-deep response register with valid/ready, DW+1 payload), instantiated for IF and DM.
- Top level holds the array, arbiter and `prio` flop.

## Test plan
- Reset: hold rst for 2 cycles, then release with both req_valid=1. Both rsp_valid=0 during reset; on the first edge after reset DM is granted (dm_req_ready=1, if_req_ready=0).
- Store then fetch: DM store addr 5, wdata 0xDEADBEEF. Next cycle IF read addr 5 gives if_rsp_data=0xDEADBEEF, err=0, one cycle after accept.
- Contention: both channels request continuously for 6 cycles with rsp_ready=1. Grants alternate DM, IF, DM, IF, DM, IF, with exactly one accept per cycle.
- Backpressure: IF read addr 7 (preloaded 0x12345678) with if_rsp_ready=0 for 4 cycles. Data stays at 0x12345678 and if_req_ready=0 throughout. Raising if_rsp_ready gives a back-to-back accept of the next request in the same cycle.
- Out of range: DM store to addr 0x400 with 0xFFFFFFFF, then load addr 0x000. The store response has err=1, data=0; the load returns the prior contents of word 0 unchanged.
- Reset mid-operation: DM load response pending with dm_rsp_ready=0, then assert rst for 1 cycle. dm_rsp_valid=0 after that edge and a store presented during rst does not modify the array (verified by a later readback).

Source files
------------

// File: rtl/microp_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : microp_mem_pkg
// Brief    : Shared defaults, port ids and range check for the memory responder
// Revision : 1.0
// ============================================================================
package microp_mem_pkg;

    localparam int c_DEF_AW = 10;
    localparam int c_DEF_DW = 32;

    typedef enum logic {
        PORT_DM = 1'b0,
        PORT_IF = 1'b1
    } port_e;

    // True when every address bit above the array index is zero.
    function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> aw) == 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/microp_mem_responder_rsp_slot.sv
`default_nettype none
// ============================================================================
// Module   : microp_rsp_slot
// Brief    : One-deep response register (data + err) with valid/ready
// Revision : 1.0
// ============================================================================
module microp_rsp_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic          i_err,
    input  logic          i_rsp_ready,
    output logic          o_free,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_err
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (i_load) begin
            // A load on a draining edge simply replaces the old response.
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_err   <= i_err;
        end else if (i_rsp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_free  = !r_valid || i_rsp_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/microp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : microp_mem_responder
// Brief    : Shared single-port word array serving IF and DM with round-robin
// Revision : 1.0
// ============================================================================
module microp_mem_responder
    import microp_mem_pkg::*;
#(
    parameter int AW = c_DEF_AW,
    parameter int DW = c_DEF_DW
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          if_req_valid,
    output logic          if_req_ready,
    input  logic [31:0]   if_req_addr,
    output logic          if_rsp_valid,
    input  logic          if_rsp_ready,
    output logic [DW-1:0] if_rsp_data,
    output logic          if_rsp_err,
    input  logic          dm_req_valid,
    output logic          dm_req_ready,
    input  logic          dm_req_we,
    input  logic [31:0]   dm_req_addr,
    input  logic [DW-1:0] dm_req_wdata,
    output logic          dm_rsp_valid,
    input  logic          dm_rsp_ready,
    output logic [DW-1:0] dm_rsp_data,
    output logic          dm_rsp_err
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    port_e         r_prio;

    logic          w_if_free, w_dm_free;
    logic          w_if_elig, w_dm_elig;
    logic          w_if_grant, w_dm_grant;
    logic [31:0]   w_addr;
    logic [AW-1:0] w_idx;
    logic          w_ok;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] w_if_data, w_dm_data;

    assign w_if_elig = if_req_valid && w_if_free;
    assign w_dm_elig = dm_req_valid && w_dm_free;

    // Ready depends on the other channel's valid only, never on our own.
    assign if_req_ready = !rst && w_if_free && !(w_dm_elig && r_prio == PORT_DM);
    assign dm_req_ready = !rst && w_dm_free && !(w_if_elig && r_prio == PORT_IF);

    assign w_if_grant = if_req_valid && if_req_ready;
    assign w_dm_grant = dm_req_valid && dm_req_ready;

    assign w_addr  = w_dm_grant ? dm_req_addr : if_req_addr;
    assign w_idx   = w_addr[AW-1:0];
    assign w_ok    = in_range(w_addr, AW);
    assign w_rdata = r_mem[w_idx];

    assign w_if_data = w_ok ? w_rdata : '0;
    assign w_dm_data = (w_ok && !dm_req_we) ? w_rdata : '0;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_prio <= PORT_DM;
        end else if (w_if_elig && w_dm_elig) begin
            r_prio <= (r_prio == PORT_DM) ? PORT_IF : PORT_DM;
        end
    end

    // Array is deliberately not reset; grants are already blocked during rst.
    always_ff @(posedge clk1) begin
        if (w_dm_grant && dm_req_we && w_ok) begin
            r_mem[w_idx] <= dm_req_wdata;
        end
    end

    microp_rsp_slot #(.DW(DW)) u_if_slot (
        .clk         (clk1),
        .rst         (rst),
        .i_load      (w_if_grant),
        .i_data      (w_if_data),
        .i_err       (!w_ok),
        .i_rsp_ready (if_rsp_ready),
        .o_free      (w_if_free),
        .o_valid     (if_rsp_valid),
        .o_data      (if_rsp_data),
        .o_err       (if_rsp_err)
    );

    microp_rsp_slot #(.DW(DW)) u_dm_slot (
        .clk         (clk1),
        .rst         (rst),
        .i_load      (w_dm_grant),
        .i_data      (w_dm_data),
        .i_err       (!w_ok),
        .i_rsp_ready (dm_rsp_ready),
        .o_free      (w_dm_free),
        .o_valid     (dm_rsp_valid),
        .o_data      (dm_rsp_data),
        .o_err       (dm_rsp_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_microp_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_microp_mem_responder
// Brief    : Directed vector table plus hand sequences for microp_mem_responder
// Revision : 1.0
// ============================================================================
module tb_microp_mem_responder;

    logic        clk1 = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
    logic [31:0] if_req_addr, if_rsp_data;
    logic        dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid, dm_rsp_ready, dm_rsp_err;
    logic [31:0] dm_req_addr, dm_req_wdata, dm_rsp_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk1 = ~clk1;

    microp_mem_responder #(.AW(10), .DW(32)) dut (
        .clk1         (clk1),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_ready (if_rsp_ready),
        .if_rsp_data  (if_rsp_data),
        .if_rsp_err   (if_rsp_err),
        .dm_req_valid (dm_req_valid),
        .dm_req_ready (dm_req_ready),
        .dm_req_we    (dm_req_we),
        .dm_req_addr  (dm_req_addr),
        .dm_req_wdata (dm_req_wdata),
        .dm_rsp_valid (dm_rsp_valid),
        .dm_rsp_ready (dm_rsp_ready),
        .dm_rsp_data  (dm_rsp_data),
        .dm_rsp_err   (dm_rsp_err)
    );

    typedef struct {
        logic        is_if;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    // Issue one request on a single channel, wait for accept, check the response.
    task automatic do_req(input vec_t v, input int idx);
        logic rdy;
        int   k;
        if (v.is_if) begin
            if_req_valid = 1'b1;
            if_req_addr  = v.addr;
        end else begin
            dm_req_valid = 1'b1;
            dm_req_we    = v.we;
            dm_req_addr  = v.addr;
            dm_req_wdata = v.wdata;
        end
        #1;
        rdy = v.is_if ? if_req_ready : dm_req_ready;
        k = 0;
        while (!rdy && k < 10) begin
            tick();
            rdy = v.is_if ? if_req_ready : dm_req_ready;
            k++;
        end
        check($sformatf("vec%0d_ready", idx), {31'd0, rdy}, 32'd1);
        tick();
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        if (v.is_if) begin
            check($sformatf("vec%0d_valid", idx), {31'd0, if_rsp_valid}, 32'd1);
            check($sformatf("vec%0d_data", idx), if_rsp_data, v.exp_data);
            check($sformatf("vec%0d_err", idx), {31'd0, if_rsp_err}, {31'd0, v.exp_err});
        end else begin
            check($sformatf("vec%0d_valid", idx), {31'd0, dm_rsp_valid}, 32'd1);
            check($sformatf("vec%0d_data", idx), dm_rsp_data, v.exp_data);
            check($sformatf("vec%0d_err", idx), {31'd0, dm_rsp_err}, {31'd0, v.exp_err});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //               is_if we   addr           wdata          exp_data       err
        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0000_0007, 32'h1234_5678, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0007, 32'h0,         32'h1234_5678, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_03FF, 32'hCAFE_F00D, 32'h0,         1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_03FF, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0,         1'b1};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,         32'h0,         1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_0005, 32'h1111_1111, 32'h0,         1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0000_0005, 32'h0,         32'h1111_1111, 1'b0};

        rst          = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 32'd2;
        if_rsp_ready = 1'b1;
        dm_req_valid = 1'b1;
        dm_req_we    = 1'b0;
        dm_req_addr  = 32'd1;
        dm_req_wdata = 32'd0;
        dm_rsp_ready = 1'b1;

        // Reset state, requests held during reset must not be accepted.
        tick();
        tick();
        check("rst_if_valid", {31'd0, if_rsp_valid}, 32'd0);
        check("rst_dm_valid", {31'd0, dm_rsp_valid}, 32'd0);
        check("rst_if_data", if_rsp_data, 32'd0);
        check("rst_dm_data", dm_rsp_data, 32'd0);
        check("rst_errs", {30'd0, if_rsp_err, dm_rsp_err}, 32'd0);
        check("rst_dm_ready", {31'd0, dm_req_ready}, 32'd0);
        check("rst_if_ready", {31'd0, if_req_ready}, 32'd0);

        // Contention: DM first after reset, then strict alternation.
        rst = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cont%0d_dm_ready", i), {31'd0, dm_req_ready}, {31'd0, (i % 2) == 0});
            check($sformatf("cont%0d_if_ready", i), {31'd0, if_req_ready}, {31'd0, (i % 2) == 1});
            tick();
            check($sformatf("cont%0d_dm_rsp", i), {31'd0, dm_rsp_valid}, {31'd0, (i % 2) == 0});
            check($sformatf("cont%0d_if_rsp", i), {31'd0, if_rsp_valid}, {31'd0, (i % 2) == 1});
        end
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        tick();
        tick();

        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i], i);
        end
        tick();

        // Backpressure on IF: held response stays put, next request waits.
        if_rsp_ready = 1'b0;
        if_req_valid = 1'b1;
        if_req_addr  = 32'd7;
        #1;
        check("bp_first_ready", {31'd0, if_req_ready}, 32'd1);
        tick();
        if_req_addr = 32'd5;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp%0d_valid", i), {31'd0, if_rsp_valid}, 32'd1);
            check($sformatf("bp%0d_data", i), if_rsp_data, 32'h1234_5678);
            check($sformatf("bp%0d_ready", i), {31'd0, if_req_ready}, 32'd0);
            tick();
        end
        if_rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'd0, if_req_ready}, 32'd1);
        tick();
        if_req_valid = 1'b0;
        check("bp_next_valid", {31'd0, if_rsp_valid}, 32'd1);
        check("bp_next_data", if_rsp_data, 32'h1111_1111);
        tick();
        check("bp_drained", {31'd0, if_rsp_valid}, 32'd0);

        // Reset mid-operation with a pending DM response and a store during rst.
        dm_rsp_ready = 1'b0;
        dm_req_valid = 1'b1;
        dm_req_we    = 1'b0;
        dm_req_addr  = 32'h3FF;
        #1;
        check("mr_ready", {31'd0, dm_req_ready}, 32'd1);
        tick();
        check("mr_pending", {31'd0, dm_rsp_valid}, 32'd1);
        check("mr_pending_data", dm_rsp_data, 32'hCAFE_F00D);
        rst          = 1'b1;
        dm_req_we    = 1'b1;
        dm_req_wdata = 32'h0BAD_0BAD;
        dm_rsp_ready = 1'b1;
        #1;
        check("mr_rst_ready", {31'd0, dm_req_ready}, 32'd0);
        tick();
        rst          = 1'b0;
        dm_req_valid = 1'b0;
        check("mr_valid_cleared", {31'd0, dm_rsp_valid}, 32'd0);
        check("mr_data_cleared", dm_rsp_data, 32'd0);
        do_req('{1'b0, 1'b0, 32'h0000_03FF, 32'h0, 32'hCAFE_F00D, 1'b0}, 12);

        // Prio returns to DM after the mid-run reset.
        if_req_valid = 1'b1;
        if_req_addr  = 32'd0;
        dm_req_valid = 1'b1;
        dm_req_we    = 1'b0;
        dm_req_addr  = 32'd0;
        #1;
        check("post_rst_dm_first", {30'd0, dm_req_ready, if_req_ready}, 32'd2);
        tick();
        if_req_valid = 1'b0;
        dm_req_valid = 1'b0;
        check("post_rst_dm_data", dm_rsp_data, 32'hA5A5_A5A5);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
